// File: rtl/cve2_obi_bus_arbiter.sv
// Merges the instruction-fetch and data OBI hosts onto one shared memory OBI port, with in-order response routing.
// Optional feature: define CVE2_OBI_ARB_PERF_EN to build the saturating contention cycle counter.
module cve2_obi_bus_arbiter #(
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   // instruction-fetch host
   input  logic        instr_req_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   input  logic [31:0] instr_addr_i,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   // data host
   input  logic        data_req_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   // shared memory device
   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i,
   // status
   output logic        busy_o,
   output logic [31:0] contention_cnt_o
);

   // Handshake rule on every port: a request is accepted on a cycle with req & gnt high, payload
   // is held stable from req rising until that cycle, and each accepted request gets exactly one
   // rvalid pulse at least one cycle later, in acceptance order.

   localparam int unsigned CW = $clog2(MaxOutstanding + 1);
   localparam int unsigned PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam logic SRC_INSTR = 1'b0;
   localparam logic SRC_DATA  = 1'b1;

   typedef enum logic [1:0] {
      ARB_OPEN   = 2'd0,
      ARB_LOCK_I = 2'd1,
      ARB_LOCK_D = 2'd2
   } arb_state_e;

   arb_state_e                state_q, state_d;
   logic [CW-1:0]             count_q, count_d;
   logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
   logic [MaxOutstanding-1:0] src_fifo_q;
   logic                      rr_q;

   logic any_req, both_req, can_issue, winner;
   logic handshake, pop, head_src;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
      return (ptr == PW'(MaxOutstanding - 1)) ? '0 : ptr + PW'(1);
   endfunction

   // Arbitration, admission and next lock state
   always_comb begin
      any_req   = instr_req_i | data_req_i;
      both_req  = instr_req_i & data_req_i;
      can_issue = (count_q < CW'(MaxOutstanding));
      mem_req_o = any_req & can_issue;
      handshake = mem_req_o & mem_gnt_i;
      winner    = SRC_INSTR;
      case (state_q)
         ARB_LOCK_I: winner = SRC_INSTR;
         ARB_LOCK_D: winner = SRC_DATA;
         default: begin
            if (both_req) winner = rr_q;
            else          winner = data_req_i ? SRC_DATA : SRC_INSTR;
         end
      endcase

      state_d = ARB_OPEN;
      if (mem_req_o && !mem_gnt_i) begin
         state_d = (winner == SRC_DATA) ? ARB_LOCK_D : ARB_LOCK_I;
      end
   end

   always_comb begin
      instr_gnt_o = handshake & (winner == SRC_INSTR);
      data_gnt_o  = handshake & (winner == SRC_DATA);

      mem_we_o    = 1'b0;
      mem_be_o    = 4'h0;
      mem_addr_o  = 32'h0;
      mem_wdata_o = 32'h0;
      if (any_req) begin
         if (winner == SRC_DATA) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
         end else begin
            mem_be_o    = 4'hF;
            mem_addr_o  = instr_addr_i;
         end
      end
   end

   // A response with nothing outstanding is a device protocol error and is dropped.
   always_comb begin
      pop      = mem_rvalid_i & (count_q != '0);
      head_src = src_fifo_q[rd_ptr_q];
      count_d  = count_q + CW'(handshake) - CW'(pop);

      instr_rvalid_o = pop & (head_src == SRC_INSTR);
      data_rvalid_o  = pop & (head_src == SRC_DATA);
      instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'h0;
      instr_err_o    = instr_rvalid_o ? mem_err_i   : 1'b0;
      data_rdata_o   = data_rvalid_o  ? mem_rdata_i : 32'h0;
      data_err_o     = data_rvalid_o  ? mem_err_i   : 1'b0;
      busy_o         = (count_q != '0);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ARB_OPEN;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         src_fifo_q <= '0;
         rr_q       <= SRC_DATA;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (handshake) begin
            src_fifo_q[wr_ptr_q] <= winner;
            wr_ptr_q             <= ptr_inc(wr_ptr_q);
            if (both_req) rr_q <= ~winner;
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
   end

`ifdef CVE2_OBI_ARB_PERF_EN
   logic [31:0] contention_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         contention_q <= 32'h0;
      end else if (both_req && mem_req_o && (contention_q != 32'hFFFF_FFFF)) begin
         contention_q <= contention_q + 32'h1;
      end
   end

   assign contention_cnt_o = contention_q;
`else
   assign contention_cnt_o = 32'h0;
`endif

   instr_payload_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (instr_req_i && !instr_gnt_o) |=> $stable(instr_addr_i));
   data_payload_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (data_req_i && !data_gnt_o) |=> $stable({data_we_i, data_be_i, data_addr_i, data_wdata_i}));
   mem_rvalid_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !$isunknown(mem_rvalid_i));
   count_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
      count_q <= CW'(MaxOutstanding));
   rvalid_has_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
      mem_rvalid_i |-> (count_q != '0));

endmodule

// File: tb/tb_cve2_obi_bus_arbiter.sv
// Bench for cve2_obi_bus_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_cve2_obi_bus_arbiter;

   localparam int MAX = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_req_i = 1'b0, instr_gnt_o, instr_rvalid_o, instr_err_o;
   logic [31:0] instr_addr_i = '0, instr_rdata_o;
   logic        data_req_i = 1'b0, data_gnt_o, data_rvalid_o, data_we_i = 1'b0, data_err_o;
   logic [3:0]  data_be_i = '0;
   logic [31:0] data_addr_i = '0, data_wdata_i = '0, data_rdata_o;
   logic        mem_req_o, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, mem_we_o, mem_err_i = 1'b0;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i = '0;
   logic        busy_o;
   logic [31:0] contention_cnt_o;

   always #5 clk = ~clk;

   cve2_obi_bus_arbiter #(.MaxOutstanding(MAX)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
      .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
      .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
      .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
      .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
      .busy_o(busy_o), .contention_cnt_o(contention_cnt_o)
   );

   int checks = 0;
   int errors = 0;

   // Host intent: a pending request is held with a fixed payload until it is granted.
   logic        i_pend = 1'b0, d_pend = 1'b0, d_we = 1'b0;
   logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
   logic [3:0]  d_be = '0;
   // Model: issuers of accepted-but-unanswered requests, oldest first (1 = data).
   logic [0:0]  exp_q[$];
   logic        m_lock = 1'b0, m_lock_id = 1'b0, m_pref = 1'b1;
   logic [31:0] m_contention = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_i(input logic [31:0] a);
      if (!i_pend) begin i_pend = 1'b1; i_addr = a; end
   endtask

   task automatic start_d(input logic we, input logic [3:0] be, input logic [31:0] a,
                          input logic [31:0] wd);
      if (!d_pend) begin d_pend = 1'b1; d_we = we; d_be = be; d_addr = a; d_wdata = wd; end
   endtask

   // One clock cycle: drive, check the combinational outputs, then advance the model.
   task automatic cycle(input logic gnt, input logic rv, input logic [31:0] rd, input logic er);
      logic exp_req, win, rv_eff, head;
      int   n;
      n      = exp_q.size();
      rv_eff = rv && (n != 0);
      @(negedge clk);
      instr_req_i  = i_pend;  instr_addr_i = i_addr;
      data_req_i   = d_pend;  data_we_i = d_we; data_be_i = d_be;
      data_addr_i  = d_addr;  data_wdata_i = d_wdata;
      mem_gnt_i    = gnt;     mem_rvalid_i = rv_eff;
      mem_rdata_i  = rv_eff ? rd : 32'h0;
      mem_err_i    = rv_eff ? er : 1'b0;
      #1;
      exp_req = (i_pend || d_pend) && (n < MAX);
      if (m_lock)                win = m_lock_id;
      else if (i_pend && d_pend) win = m_pref;
      else                       win = d_pend;
      chk("mem_req", {31'h0, mem_req_o}, {31'h0, exp_req});
      chk("instr_gnt", {31'h0, instr_gnt_o}, {31'h0, exp_req && gnt && !win});
      chk("data_gnt", {31'h0, data_gnt_o}, {31'h0, exp_req && gnt && win});
      if (exp_req) begin
         chk("mem_addr", mem_addr_o, win ? d_addr : i_addr);
         chk("mem_we", {31'h0, mem_we_o}, {31'h0, win && d_we});
         chk("mem_be", {28'h0, mem_be_o}, {28'h0, win ? d_be : 4'hF});
         chk("mem_wdata", mem_wdata_o, win ? d_wdata : 32'h0);
      end
      head = (n != 0) ? exp_q[0] : 1'b0;
      chk("instr_rvalid", {31'h0, instr_rvalid_o}, {31'h0, rv_eff && !head});
      chk("data_rvalid", {31'h0, data_rvalid_o}, {31'h0, rv_eff && head});
      if (rv_eff) begin
         chk("instr_rdata", instr_rdata_o, head ? 32'h0 : rd);
         chk("instr_err", {31'h0, instr_err_o}, {31'h0, !head && er});
         chk("data_rdata", data_rdata_o, head ? rd : 32'h0);
         chk("data_err", {31'h0, data_err_o}, {31'h0, head && er});
      end
      chk("busy", {31'h0, busy_o}, {31'h0, n != 0});
`ifdef CVE2_OBI_ARB_PERF_EN
      chk("contention", contention_cnt_o, m_contention);
      if (i_pend && d_pend && exp_req && m_contention != 32'hFFFF_FFFF) m_contention++;
`else
      chk("contention", contention_cnt_o, 32'h0);
`endif
      if (rv_eff) void'(exp_q.pop_front());
      if (exp_req && gnt) begin
         exp_q.push_back(win);
         if (i_pend && d_pend) m_pref = !win;
         if (win) d_pend = 1'b0;
         else     i_pend = 1'b0;
      end
      m_lock    = exp_req && !gnt;
      m_lock_id = win;
      @(posedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      mem_rdata_i = 32'h0; mem_err_i = 1'b0;
      i_pend = 1'b0; d_pend = 1'b0; exp_q.delete();
      m_lock = 1'b0; m_pref = 1'b1; m_contention = 32'h0;
      #1;
      chk("rst_busy", {31'h0, busy_o}, 32'h0);
      chk("rst_mem_req", {31'h0, mem_req_o}, 32'h0);
      chk("rst_gnt", {30'h0, instr_gnt_o, data_gnt_o}, 32'h0);
      chk("rst_rvalid", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h0);
      chk("rst_contention", contention_cnt_o, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
   endtask

   task automatic drain();
      for (int k = 0; k < 8 && exp_q.size() != 0; k++) cycle(1'b0, 1'b1, $urandom, 1'b0);
      chk("drained", exp_q.size(), 32'h0);
   endtask

   initial begin
      do_reset();

      // fetch only, same-cycle grant, response one cycle later
      start_i(32'h0000_0080);
      cycle(1'b1, 1'b0, 32'h0, 1'b0);
      cycle(1'b0, 1'b1, 32'h0000_0013, 1'b0);

      // both hosts every cycle with gnt always high: data first, then alternating
      for (int k = 0; k < 4; k++) begin
         start_i(32'h1000 + 32'(k * 4));
         start_d(1'b0, 4'hF, 32'h2000 + 32'(k * 4), 32'h0);
         cycle(1'b1, 1'b1, $urandom, 1'b0);
      end
      drain();

      // store held against a stalled device while fetch rises
      start_d(1'b1, 4'h3, 32'h0000_0100, 32'hCAFE_F00D);
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      start_i(32'h0000_0200);
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      cycle(1'b1, 1'b0, 32'h0, 1'b0);
      cycle(1'b1, 1'b1, 32'h0, 1'b0);
      drain();

      // outstanding limit, then pop with grant at count 1
      for (int k = 0; k < 3; k++) begin
         start_i(32'h3000 + 32'(k * 4));
         cycle(1'b1, 1'b0, 32'h0, 1'b0);
      end
      cycle(1'b1, 1'b1, 32'h1111_1111, 1'b0);
      start_i(32'h3100);
      cycle(1'b1, 1'b1, 32'h2222_2222, 1'b0);
      chk("count_kept", exp_q.size(), 32'h1);
      drain();

      // data load with bus error
      start_d(1'b0, 4'hF, 32'h0000_0400, 32'h0);
      cycle(1'b1, 1'b0, 32'h0, 1'b0);
      cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);

      // random traffic
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 2) != 0) start_i({$urandom_range(0, 255), 2'b00});
         if ($urandom_range(0, 2) != 0)
            start_d(1'($urandom), 4'($urandom_range(1, 15)), $urandom, $urandom);
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) < 3, $urandom,
               $urandom_range(0, 7) == 0);
      end
      drain();

      // reset with two outstanding, then a normal request
      start_i(32'h5000);
      cycle(1'b1, 1'b0, 32'h0, 1'b0);
      start_d(1'b1, 4'hF, 32'h5004, 32'h1234_5678);
      cycle(1'b1, 1'b0, 32'h0, 1'b0);
      do_reset();
      start_i(32'h6000);
      cycle(1'b1, 1'b0, 32'h0, 1'b0);
      cycle(1'b0, 1'b1, 32'hABCD_0001, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
